// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: requester ids, FSM states, latency counter width.
// Build option MEM_ARB_RR_EN selects round-robin instead of fixed priority.
package mem_arb_pkg;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory command signals of mem_arbiter.
// slave is the arbiter's view, master the surrounding datapath/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic [DATA_W-1:0]   m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_be
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_arbiter.
// MEM_ARB_RR_EN: round-robin on conflict; otherwise DATA beats INSTR.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t winner,
  output logic   valid
);

  assign valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = INSTR;
    unique case ({i_req, d_req})
      2'b11:   winner = (last_owner == DATA) ? INSTR : DATA;
      2'b01:   winner = DATA;
      default: winner = INSTR;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last_owner;

  always_comb begin
    winner = INSTR;
    if (d_req) winner = DATA;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store ports.
// MEM_ARB_RR_EN: round-robin arbitration; default is fixed DATA priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;
  localparam logic [LAT_CNT_W-1:0] CNT_ONE = LAT_CNT_W'(1);

  logic [0:0]           state;
  logic [LAT_CNT_W-1:0] lat_cnt;
  owner_t               owner;
  owner_t               last_owner;
  owner_t               winner;
  logic                 win_vld;
  logic                 own_we;
  logic                 grant;
  logic                 pick_d;
  logic                 resp;

  mem_arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_owner (last_owner),
    .winner     (winner),
    .valid      (win_vld)
  );

  // reset gating keeps every output low while reset is held
  assign grant  = !reset && (state == ST_IDLE) && win_vld;
  assign pick_d = (winner == DATA);
  assign resp   = (state == ST_BUSY) && (lat_cnt == CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      owner   <= INSTR;
      own_we  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            state   <= ST_BUSY;
            owner   <= winner;
            own_we  <= pick_d && bus.d_we;
            lat_cnt <= LAT_CNT_W'(MEM_LAT);
          end
        end
        ST_BUSY: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          if (lat_cnt == CNT_ONE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_owner <= INSTR;
    else if (grant) last_owner <= winner;
  end
`else
  assign last_owner = INSTR;
`endif

  assign bus.i_gnt = grant && !pick_d;
  assign bus.d_gnt = grant && pick_d;

  assign bus.m_req   = grant;
  assign bus.m_we    = grant && pick_d && bus.d_we;
  assign bus.m_addr  = !grant ? {ADDR_W{1'b0}}
                     : pick_d ? bus.d_addr : bus.i_addr;
  assign bus.m_wdata = (grant && pick_d) ? bus.d_wdata
                                         : {DATA_W{1'b0}};
  assign bus.m_be    = (grant && pick_d) ? bus.d_be
                                         : {BE_W{1'b0}};

  assign bus.i_rvalid = resp && (owner == INSTR);
  assign bus.d_rvalid = resp && (owner == DATA);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata
                                     : {DATA_W{1'b0}};
  // stores acknowledge with zero data
  assign bus.d_rdata  = (bus.d_rvalid && !own_we) ? bus.m_rdata
                                                  : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 (k=0) and MEM_LAT=3 (k=1).
// Expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [1:0]       ireq, dreq, dwe;
  logic [1:0][31:0] iaddr, daddr, dwdata;
  logic [1:0][3:0]  dbe;

  logic [1:0]       igt, irv, dgt, drv, mreq, mwe;
  logic [1:0][31:0] irdata, drdata, maddr, mwdata, mrdata;
  logic [1:0][3:0]  mbe;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] pat(int g, int i);
    return 32'hC000_0000 | (g << 16) | i;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_arbiter_if bus ();

    assign bus.i_req   = ireq[g];
    assign bus.i_addr  = iaddr[g];
    assign bus.d_req   = dreq[g];
    assign bus.d_we    = dwe[g];
    assign bus.d_addr  = daddr[g];
    assign bus.d_wdata = dwdata[g];
    assign bus.d_be    = dbe[g];
    assign bus.m_rdata = mrdata[g];

    assign igt[g]    = bus.i_gnt;
    assign irv[g]    = bus.i_rvalid;
    assign irdata[g] = bus.i_rdata;
    assign dgt[g]    = bus.d_gnt;
    assign drv[g]    = bus.d_rvalid;
    assign drdata[g] = bus.d_rdata;
    assign mreq[g]   = bus.m_req;
    assign mwe[g]    = bus.m_we;
    assign maddr[g]  = bus.m_addr;
    assign mwdata[g] = bus.m_wdata;
    assign mbe[g]    = bus.m_be;

    mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (LAT)
    ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );

    // memory model: data valid only in the cycle MEM_LAT after m_req
    logic [31:0] mem [0:63];
    logic [31:0] rd;
    logic [3:0]  mcnt;

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = pat(g, i);
      mcnt = '0;
      rd   = '0;
    end

    always @(posedge clk) begin
      if (mreq[g]) begin
        for (int b = 0; b < 4; b++)
          if (mwe[g] && mbe[g][b])
            mem[maddr[g][7:2]][8*b +: 8] <= mwdata[g][8*b +: 8];
        rd   <= mem[maddr[g][7:2]];
        mcnt <= 4'(LAT);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 4'd1;
      end
    end

    assign mrdata[g] = (mcnt == 4'd1) ? rd : 32'hBAD0_BAD0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic quiet(int k);
    ireq[k] = 0; dreq[k] = 0; dwe[k] = 0;
    iaddr[k] = '0; daddr[k] = '0; dwdata[k] = '0; dbe[k] = '0;
  endtask

  task automatic check_quiet(int k);
    check($sformatf("q%0d_igt", k), igt[k], 0);
    check($sformatf("q%0d_dgt", k), dgt[k], 0);
    check($sformatf("q%0d_irv", k), irv[k], 0);
    check($sformatf("q%0d_drv", k), drv[k], 0);
    check($sformatf("q%0d_mreq", k), mreq[k], 0);
    check($sformatf("q%0d_maddr", k), maddr[k], 0);
    check($sformatf("q%0d_irdata", k), irdata[k], 0);
    check($sformatf("q%0d_drdata", k), drdata[k], 0);
  endtask

  task automatic xact(int k, bit isd, bit we, logic [31:0] a,
                      logic [31:0] wd, logic [3:0] be, logic [31:0] exp);
    int lat = (k == 0) ? 1 : 3;
    string p = $sformatf("x%0d_%s", k, isd ? (we ? "st" : "ld") : "if");
    @(negedge clk);
    if (isd) begin
      dreq[k] = 1; dwe[k] = we; daddr[k] = a; dwdata[k] = wd; dbe[k] = be;
    end else begin
      ireq[k] = 1; iaddr[k] = a;
    end
    #1;
    check({p, "_gnt"}, isd ? dgt[k] : igt[k], 1);
    check({p, "_ogt"}, isd ? igt[k] : dgt[k], 0);
    check({p, "_mreq"}, mreq[k], 1);
    check({p, "_maddr"}, maddr[k], a);
    check({p, "_mwe"}, mwe[k], we);
    if (isd && we) begin
      check({p, "_mwdata"}, mwdata[k], wd);
      check({p, "_mbe"}, mbe[k], be);
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) quiet(k);
      #1;
      check({p, "_rv"}, isd ? drv[k] : irv[k], c == lat);
      check({p, "_orv"}, isd ? irv[k] : drv[k], 0);
      check({p, "_busy_mreq"}, mreq[k], 0);
      if (c == lat) begin
        check({p, "_rdata"}, isd ? drdata[k] : irdata[k], exp);
        check({p, "_ordata"}, isd ? irdata[k] : drdata[k], 0);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic conflict(int k);
    int lat = (k == 0) ? 1 : 3;
    int per = lat + 1;
    bit d_wins;
    for (int c = 0; c < 4 * per; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ireq[k] = 1; iaddr[k] = 32'h40;
        dreq[k] = 1; dwe[k] = 0; daddr[k] = 32'h30;
      end
      #1;
`ifdef MEM_ARB_RR_EN
      d_wins = ((c / per) % 2) == 0;
`else
      d_wins = 1'b1;
`endif
      check($sformatf("cf%0d_dgt", k), dgt[k], (c % per == 0) && d_wins);
      check($sformatf("cf%0d_igt", k), igt[k], (c % per == 0) && !d_wins);
      check($sformatf("cf%0d_drv", k), drv[k], (c % per == lat) && d_wins);
      check($sformatf("cf%0d_irv", k), irv[k], (c % per == lat) && !d_wins);
      if (c % per == lat)
        check($sformatf("cf%0d_rdata", k), d_wins ? drdata[k] : irdata[k],
              d_wins ? pat(k, 12) : pat(k, 16));
    end
    @(negedge clk);
    quiet(k);
  endtask

  initial begin
    rst = 1;
    quiet(0);
    quiet(1);
    repeat (2) @(negedge clk);
    #1;
    check_quiet(0);
    check_quiet(1);
    @(negedge clk);
    rst = 0;

    // MEM_LAT=1: fetch, store, load back-to-back
    xact(0, 0, 0, 32'h10, '0, '0, pat(0, 4));
    xact(0, 1, 1, 32'h08, 32'h1234_5678, 4'hF, 32'h0);
    xact(0, 1, 0, 32'h08, '0, '0, 32'h1234_5678);
    xact(0, 0, 0, 32'h08, '0, '0, 32'h1234_5678);

    // MEM_LAT=3: store, load, partial store, fetch of same word
    xact(1, 1, 1, 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h0);
    xact(1, 1, 0, 32'h20, '0, '0, 32'hDEAD_BEEF);
    xact(1, 1, 1, 32'h20, 32'h1111_2222, 4'h3, 32'h0);
    xact(1, 1, 0, 32'h20, '0, '0, 32'hDEAD_2222);
    xact(1, 0, 0, 32'h20, '0, '0, 32'hDEAD_2222);

    pulse_reset();
    conflict(1);
    conflict(0);

    // fetch arriving during a busy data access waits for IDLE
    @(negedge clk);
    dreq[1] = 1; dwe[1] = 0; daddr[1] = 32'h30;
    #1;
    check("hold_dgt", dgt[1], 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        quiet(1);
        ireq[1] = 1; iaddr[1] = 32'h44;
      end
      #1;
      check("hold_igt_busy", igt[1], 0);
      check("hold_drv", drv[1], c == 3);
    end
    check("hold_drdata", drdata[1], pat(1, 12));
    @(negedge clk);
    #1;
    check("hold_igt_idle", igt[1], 1);
    check("hold_maddr", maddr[1], 32'h44);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) quiet(1);
      #1;
      check("hold_irv", irv[1], c == 3);
    end
    check("hold_irdata", irdata[1], pat(1, 17));

    // reset one cycle after a fetch grant
    @(negedge clk);
    ireq[1] = 1; iaddr[1] = 32'h10;
    #1;
    check("rst_igt", igt[1], 1);
    @(negedge clk);
    quiet(1);
    rst = 1;
    #1;
    check_quiet(1);
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("rst_no_irv", irv[1], 0);
    end
    xact(1, 1, 0, 32'h20, '0, '0, 32'hDEAD_2222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
